// File: rtl/hci_log_xbar_qos.sv
// Word-interleaved N_IN x N_MEM crossbar with two-class QoS arbitration per bank,
// round-robin within each class and a starvation guard. Optional perf counters: HCI_LOG_XBAR_QOS_PERF_EN.
module hci_log_xbar_qos #(
   parameter int unsigned N_CH0 = 16,
   parameter int unsigned N_CH1 = 4,
   parameter int unsigned N_MEM = 32,
   parameter int unsigned AW    = 32,
   parameter int unsigned AWM   = 12,
   parameter int unsigned DW    = 32,
   parameter int unsigned SW    = 8,
   parameter int unsigned CNT_W = 16,
   localparam int unsigned N_IN = N_CH0 + N_CH1,
   localparam int unsigned BOFF = $clog2(DW / 8),
   localparam int unsigned BSEL = $clog2(N_MEM),
   localparam int unsigned IW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
`ifdef HCI_LOG_XBAR_QOS_PERF_EN
   input  logic                   perf_clr_i,
   output logic [N_IN*CNT_W-1:0]  perf_conflict_o,
`endif
   input  logic                   invert_prio_i,
   input  logic [SW-1:0]          max_stall_i,
   input  logic [N_IN-1:0]        core_req_i,
   input  logic [N_IN*AW-1:0]     core_add_i,
   input  logic [N_IN-1:0]        core_wen_i,
   input  logic [N_IN*DW-1:0]     core_wdata_i,
   input  logic [N_IN*DW/8-1:0]   core_be_i,
   output logic [N_IN-1:0]        core_gnt_o,
   output logic [N_IN-1:0]        core_r_valid_o,
   output logic [N_IN*DW-1:0]     core_r_data_o,
   output logic [N_MEM-1:0]       mem_req_o,
   output logic [N_MEM*AWM-1:0]   mem_add_o,
   output logic [N_MEM-1:0]       mem_wen_o,
   output logic [N_MEM*DW-1:0]    mem_wdata_o,
   output logic [N_MEM*DW/8-1:0]  mem_be_o,
   input  logic [N_MEM-1:0]       mem_gnt_i,
   input  logic [N_MEM*DW-1:0]    mem_r_data_i
);

   logic [BSEL-1:0] core_bank_s [N_IN];
   logic [N_MEM-1:0] fire_s;
   logic [IW-1:0]    win_idx_s [N_MEM];
   logic [N_MEM-1:0] resp_vld_s;
   logic [IW-1:0]    resp_id_s [N_MEM];
   logic             addr_unused_s;

   // First requester at or after ptr within a class of n members; returns the class-relative offset.
   function automatic logic [IW-1:0] rr_pick(input logic [N_IN-1:0] req, input int unsigned n,
                                              input logic [IW-1:0] ptr);
      logic [IW-1:0] off;
      logic          found;
      logic          hit;
      int unsigned   o;
      off   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < N_IN; k++) begin
         o     = 32'(ptr) + k;
         o     = (o >= n) ? (o - n) : o;
         hit   = (k < n) & ~found & req[IW'(o)];
         off   = hit ? IW'(o) : off;
         found = found | hit;
      end
      return off;
   endfunction

   // Upper and byte-offset address bits carry no routing information.
   assign addr_unused_s = ^core_add_i;

   for (genvar i = 0; i < N_IN; i++) begin : g_core
      assign core_bank_s[i] = core_add_i[i*AW+BOFF +: BSEL];
      assign core_gnt_o[i]  = fire_s[core_bank_s[i]] & (win_idx_s[core_bank_s[i]] == IW'(i));
   end

   for (genvar b = 0; b < N_MEM; b++) begin : g_bank
      logic [N_IN-1:0]   match_s;
      logic              any0_s, any1_s, any_hi_s, any_lo_s;
      logic              lo_wins_s, sel_ch1_s, fire_b_s, sel_s;
      logic [IW-1:0]     off0_s, off1_s, win_s;
      logic [AWM-1:0]    add_s;
      logic              wen_s;
      logic [DW-1:0]     wdata_s;
      logic [DW/8-1:0]   be_s;
      logic [IW-1:0]     ptr0_r, ptr1_r;
      logic [SW-1:0]     stall_r;
      logic              resp_vld_r;
      logic [IW-1:0]     resp_id_r;

      // Class selection, round-robin pick and winner mux for this bank
      always_comb begin
         match_s = '0;
         add_s   = '0;
         wen_s   = 1'b0;
         wdata_s = '0;
         be_s    = '0;
         sel_s   = 1'b0;
         for (int i = 0; i < N_IN; i++) begin
            match_s[i] = core_req_i[i] & (core_bank_s[i] == BSEL'(b));
         end
         any0_s    = |match_s[N_CH0-1:0];
         any1_s    = |match_s[N_IN-1:N_CH0];
         any_hi_s  = invert_prio_i ? any1_s : any0_s;
         any_lo_s  = invert_prio_i ? any0_s : any1_s;
         lo_wins_s = any_lo_s & (~any_hi_s | ((max_stall_i != '0) & (stall_r == max_stall_i)));
         // CH1 is the low class unless priorities are inverted
         sel_ch1_s = invert_prio_i ^ lo_wins_s;
         off0_s    = rr_pick(match_s, N_CH0, ptr0_r);
         off1_s    = rr_pick(match_s >> N_CH0, N_CH1, ptr1_r);
         win_s     = sel_ch1_s ? (IW'(N_CH0) + off1_s) : off0_s;
         fire_b_s  = (|match_s) & mem_gnt_i[b];
         for (int i = 0; i < N_IN; i++) begin
            sel_s   = (win_s == IW'(i));
            add_s   = add_s   | ({AWM{sel_s}} & core_add_i[i*AW+BOFF+BSEL +: AWM]);
            wen_s   = wen_s   | (sel_s & core_wen_i[i]);
            wdata_s = wdata_s | ({DW{sel_s}} & core_wdata_i[i*DW +: DW]);
            be_s    = be_s    | ({(DW/8){sel_s}} & core_be_i[i*DW/8 +: DW/8]);
         end
      end

      // Round-robin pointers, starvation counter and response tag for this bank
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            ptr0_r     <= '0;
            ptr1_r     <= '0;
            stall_r    <= '0;
            resp_vld_r <= 1'b0;
            resp_id_r  <= '0;
         end else begin
            resp_vld_r <= fire_b_s;
            if (fire_b_s) begin
               resp_id_r <= win_s;
               if (sel_ch1_s) begin
                  ptr1_r <= (off1_s == IW'(N_CH1 - 1)) ? '0 : off1_s + IW'(1);
               end else begin
                  ptr0_r <= (off0_s == IW'(N_CH0 - 1)) ? '0 : off0_s + IW'(1);
               end
               if (lo_wins_s) begin
                  stall_r <= '0;
               end else if (any_lo_s) begin
                  stall_r <= (stall_r == '1) ? stall_r : stall_r + SW'(1);
               end else begin
                  stall_r <= stall_r;
               end
            end
         end
      end

      assign fire_s[b]                   = fire_b_s;
      assign win_idx_s[b]                = win_s;
      assign resp_vld_s[b]               = resp_vld_r;
      assign resp_id_s[b]                = resp_id_r;
      assign mem_req_o[b]                = |match_s;
      assign mem_add_o[b*AWM +: AWM]     = add_s;
      assign mem_wen_o[b]                = wen_s;
      assign mem_wdata_o[b*DW +: DW]     = wdata_s;
      assign mem_be_o[b*DW/8 +: DW/8]    = be_s;
   end

   // Route each bank's response to the core that was granted last cycle; suppressed while in reset
   always_comb begin
      logic hit;
      hit            = 1'b0;
      core_r_valid_o = '0;
      core_r_data_o  = '0;
      for (int b = 0; b < N_MEM; b++) begin
         for (int i = 0; i < N_IN; i++) begin
            hit               = resp_vld_s[b] & ~rst_i & (resp_id_s[b] == IW'(i));
            core_r_valid_o[i] = core_r_valid_o[i] | hit;
            core_r_data_o[i*DW +: DW] = core_r_data_o[i*DW +: DW] | ({DW{hit}} & mem_r_data_i[b*DW +: DW]);
         end
      end
   end

`ifdef HCI_LOG_XBAR_QOS_PERF_EN
   for (genvar i = 0; i < N_IN; i++) begin : g_perf
      logic [CNT_W-1:0] cnt_r;

      // Saturating count of cycles this core requested but was not granted
      always_ff @(posedge clk_i) begin
         if (rst_i || perf_clr_i) begin
            cnt_r <= '0;
         end else if (core_req_i[i] && !core_gnt_o[i] && (cnt_r != '1)) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end

      assign perf_conflict_o[i*CNT_W +: CNT_W] = cnt_r;
   end
`endif

endmodule

// File: tb/tb_hci_log_xbar_qos.sv
// Scoreboard bench for hci_log_xbar_qos: expected grants and responses are queued by the
// stimulus and compared by an independent negedge monitor.
module tb_hci_log_xbar_qos;
   localparam int N_CH0 = 16, N_CH1 = 4, N_IN = 20, N_MEM = 32;
   localparam int AW = 32, AWM = 12, DW = 32, SW = 8, CNT_W = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  invert_prio;
   logic [SW-1:0]         max_stall;
   logic [N_IN-1:0]       core_req;
   logic [N_IN*AW-1:0]    core_add;
   logic [N_IN-1:0]       core_wen;
   logic [N_IN*DW-1:0]    core_wdata;
   logic [N_IN*DW/8-1:0]  core_be;
   logic [N_IN-1:0]       core_gnt;
   logic [N_IN-1:0]       core_r_valid;
   logic [N_IN*DW-1:0]    core_r_data;
   logic [N_MEM-1:0]      mem_req;
   logic [N_MEM*AWM-1:0]  mem_add;
   logic [N_MEM-1:0]      mem_wen;
   logic [N_MEM*DW-1:0]   mem_wdata;
   logic [N_MEM*DW/8-1:0] mem_be;
   logic [N_MEM-1:0]      mem_gnt;
   logic [N_MEM*DW-1:0]   mem_r_data = '0;
`ifdef HCI_LOG_XBAR_QOS_PERF_EN
   logic                  perf_clr;
   logic [N_IN*CNT_W-1:0] perf_conflict;
`endif

   typedef struct packed {
      logic [7:0]  core;
      logic [31:0] data;
   } resp_t;

   logic [N_IN-1:0] gnt_q [$];
   resp_t           resp_q [$];
   logic [31:0]     core_addr [N_IN];
   int              n_chk = 0;
   int              n_fail = 0;

   always #5 clk = ~clk;

   hci_log_xbar_qos dut (
      .clk_i          (clk),
      .rst_i          (rst),
`ifdef HCI_LOG_XBAR_QOS_PERF_EN
      .perf_clr_i     (perf_clr),
      .perf_conflict_o(perf_conflict),
`endif
      .invert_prio_i  (invert_prio),
      .max_stall_i    (max_stall),
      .core_req_i     (core_req),
      .core_add_i     (core_add),
      .core_wen_i     (core_wen),
      .core_wdata_i   (core_wdata),
      .core_be_i      (core_be),
      .core_gnt_o     (core_gnt),
      .core_r_valid_o (core_r_valid),
      .core_r_data_o  (core_r_data),
      .mem_req_o      (mem_req),
      .mem_add_o      (mem_add),
      .mem_wen_o      (mem_wen),
      .mem_wdata_o    (mem_wdata),
      .mem_be_o       (mem_be),
      .mem_gnt_i      (mem_gnt),
      .mem_r_data_i   (mem_r_data)
   );

   // Bank model: data returned one cycle after req&gnt encodes bank number and word address
   always @(posedge clk) begin
      for (int b = 0; b < N_MEM; b++) begin
         if (mem_req[b] && mem_gnt[b])
            mem_r_data[b*DW +: DW] <= {8'hD0, 3'b000, 5'(b), 4'h0, mem_add[b*AWM +: AWM]};
      end
   end

   function automatic logic [31:0] bank_data(input logic [31:0] add);
      return {8'hD0, 3'b000, add[6:2], 4'h0, add[18:7]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic expect_cycle(input logic [N_IN-1:0] g, input bit resp);
      gnt_q.push_back(g);
      for (int c = 0; c < N_IN; c++) begin
         if (resp && g[c]) resp_q.push_back('{core: 8'(c), data: bank_data(core_addr[c])});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int c, input logic [31:0] a, input logic w);
      core_req[c]            = 1'b1;
      core_add[c*AW +: AW]   = a;
      core_wen[c]            = w;
      core_addr[c]           = a;
   endtask

   function automatic logic [N_IN-1:0] onehot(input int c);
      logic [N_IN-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   // Monitor: compares grants every scheduled cycle and pops a response per r_valid
   always @(negedge clk) begin
      logic [N_IN-1:0] eg;
      resp_t           r;
      if (gnt_q.size() > 0) begin
         eg = gnt_q.pop_front();
         chk("core_gnt", 64'(core_gnt), 64'(eg));
      end
      for (int c = 0; c < N_IN; c++) begin
         if (core_r_valid[c]) begin
            if (resp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_r_valid: actual valid on core %0d required none", c);
            end else begin
               r = resp_q.pop_front();
               chk("r_valid_core", 64'(c), 64'(r.core));
               chk("r_data", 64'(core_r_data[c*DW +: DW]), 64'(r.data));
            end
         end else begin
            chk("r_data_idle", 64'(core_r_data[c*DW +: DW]), 64'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N_IN-1:0] g;
      rst = 1'b1; invert_prio = 1'b0; max_stall = 8'd0;
      core_req = '0; core_add = '0; core_wen = '0; core_wdata = '0; core_be = '0;
      mem_gnt = '1;
`ifdef HCI_LOG_XBAR_QOS_PERF_EN
      perf_clr = 1'b0;
`endif
      for (int c = 0; c < N_IN; c++) core_addr[c] = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_r_valid", 64'(core_r_valid), 64'd0);
      chk("reset_r_data", 64'(core_r_data[63:0]), 64'd0);
      chk("reset_gnt", 64'(core_gnt), 64'd0);
      chk("reset_mem_req", 64'(mem_req), 64'd0);
      tick();
      rst = 1'b0;

      // Single read: 0x44 -> bank 17, word 0
      req(0, 32'h0000_0044, 1'b1);
      expect_cycle(onehot(0), 1'b1);
      @(negedge clk);
      chk("rd_mem_req", 64'(mem_req), 64'h0002_0000);
      chk("rd_mem_add", 64'(mem_add[17*AWM +: AWM]), 64'h0);
      chk("rd_mem_wen", 64'(mem_wen[17]), 64'd1);
      tick();
      // Single write: 0x1234 -> bank 13, word 0x24
      core_req = '0;
      req(3, 32'h0000_1234, 1'b0);
      core_wdata[3*DW +: DW] = 32'hCAFE_0003;
      core_be[3*4 +: 4]      = 4'b0101;
      expect_cycle(onehot(3), 1'b1);
      @(negedge clk);
      chk("rd_resp_data_core0", 64'(core_r_data[0 +: DW]), 64'hD011_0000);
      chk("wr_mem_req", 64'(mem_req), 64'h0000_2000);
      chk("wr_mem_add", 64'(mem_add[13*AWM +: AWM]), 64'h024);
      chk("wr_mem_wen", 64'(mem_wen[13]), 64'd0);
      chk("wr_mem_wdata", 64'(mem_wdata[13*DW +: DW]), 64'hCAFE_0003);
      chk("wr_mem_be", 64'(mem_be[13*4 +: 4]), 64'h5);
      tick();
      core_req = '0;
      expect_cycle('0, 1'b0);
      tick();

      // Round robin on bank 3
      req(0, 32'h0000_000C, 1'b1);
      req(1, 32'h0000_000C, 1'b1);
      req(2, 32'h0000_000C, 1'b1);
      for (int k = 0; k < 6; k++) begin
         expect_cycle(onehot(k % 3), 1'b1);
         tick();
      end
      core_req = '0;
      expect_cycle('0, 1'b0);
      tick();

      // Strict priority on bank 5, then inverted
      req(0, 32'h0000_0014, 1'b1);
      req(16, 32'h0000_0014, 1'b1);
      repeat (10) begin
         expect_cycle(onehot(0), 1'b1);
         tick();
      end
      invert_prio = 1'b1;
      repeat (3) begin
         expect_cycle(onehot(16), 1'b1);
         tick();
      end
      invert_prio = 1'b0;
      core_req = '0;
      expect_cycle('0, 1'b0);
      tick();

      // Starvation guard on bank 6 with limit 3
      max_stall = 8'd3;
      req(0, 32'h0000_0018, 1'b1);
      req(17, 32'h0000_0018, 1'b1);
      repeat (2) begin
         repeat (3) begin
            expect_cycle(onehot(0), 1'b1);
            tick();
         end
         expect_cycle(onehot(17), 1'b1);
         tick();
      end
      max_stall = 8'd0;
      core_req = '0;
      expect_cycle('0, 1'b0);
      tick();

      // Backpressure on bank 5: pointer (at 1) must not move while gnt is low
      mem_gnt[5] = 1'b0;
      req(0, 32'h0000_0014, 1'b1);
      req(2, 32'h0000_0014, 1'b1);
      repeat (4) begin
         expect_cycle('0, 1'b0);
         @(negedge clk);
         chk("bp_mem_req", 64'(mem_req[5]), 64'd1);
         tick();
      end
      mem_gnt[5] = 1'b1;
      expect_cycle(onehot(2), 1'b1);
      tick();
      expect_cycle(onehot(0), 1'b1);
      tick();
      core_req = '0;
      expect_cycle('0, 1'b0);
      tick();

      // Reset in the cycle after a grant drops the response
      req(0, 32'h0000_0044, 1'b1);
      expect_cycle(onehot(0), 1'b0);
      tick();
      core_req = '0;
      rst = 1'b1;
      expect_cycle('0, 1'b0);
      tick();
      rst = 1'b0;
      expect_cycle('0, 1'b0);
`ifdef HCI_LOG_XBAR_QOS_PERF_EN
      @(negedge clk);
      chk("perf_after_reset", 64'(perf_conflict[63:0]), 64'd0);
`endif
      tick();
      // Bank 3 pointer restarts at 0 after reset: core 2 beats core 5
      req(2, 32'h0000_000C, 1'b1);
      req(5, 32'h0000_000C, 1'b1);
      expect_cycle(onehot(2), 1'b1);
      tick();
      core_req = '0;
      expect_cycle('0, 1'b0);
      tick();
      tick();

      chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
      chk("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
